// File: rtl/program_loader.sv
// Host-side CPU programming loader. It holds a RAM image written by the host and
// streams it byte-by-byte into the CPU while the CPU is held in programming mode.
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             img_we,
    input  logic [$clog2(RAM_BYTES)-1:0]     img_addr,
    input  logic [7:0]                       img_wdata,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             cpu_ready,
    input  logic                             cpu_done_load,
    output logic                             programming,
    output logic [7:0]                       prog_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(RAM_BYTES+1)-1:0]   byte_count
);

    localparam int AW = $clog2(RAM_BYTES);
    localparam int CW = $clog2(RAM_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(RAM_BYTES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAM_BYTES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_WAIT_DONE,
        S_RELEASE,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [7:0]      r_image [RAM_BYTES];
    logic [AW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic            r_programming;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [7:0]      r_prog_data;
    logic [CW-1:0]   r_byte_count;

    logic            w_img_open;
    logic            w_active;
    logic            w_in_stream;
    logic            w_in_wait;
    logic            w_accept;
    logic            w_last;
    logic            w_timer_expired;
    logic            w_abort;
    logic            w_fault;
    logic            w_release;
    logic [AW-1:0]   w_idx_next;
    logic [CW-1:0]   w_count_next;

    assign w_img_open      = (r_state == S_IDLE) || (r_state == S_ERROR);
    assign w_in_stream     = (r_state == S_STREAM);
    assign w_in_wait       = (r_state == S_WAIT_DONE);
    assign w_active        = (r_state == S_ARM) || w_in_stream || w_in_wait;
    assign w_accept        = w_in_stream && cpu_ready;
    assign w_last          = (r_idx == LAST_IDX);
    assign w_timer_expired = (r_timer == TIMER_LAST);
    assign w_idx_next      = r_idx + AW'(1);
    assign w_count_next    = (r_byte_count == FULL_COUNT) ? r_byte_count
                                                          : r_byte_count + CW'(1);

    // A done_load that coincides with the final accept counts as a clean finish.
    assign w_abort   = abort && w_active;
    assign w_fault   = (w_in_stream && cpu_done_load && !(w_accept && w_last))
                     || (w_in_stream && !cpu_ready && !cpu_done_load && w_timer_expired)
                     || (w_in_wait && !cpu_done_load && w_timer_expired);
    assign w_release = (w_accept && w_last && cpu_done_load)
                     || (w_in_wait && cpu_done_load);

    // NOTE: the image is a plain memory with no reset so the host's contents survive rst.
    always_ff @(posedge clk) begin
        if (img_we && w_img_open) begin
            r_image[img_addr] <= img_wdata;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_programming <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_prog_data   <= '0;
            r_byte_count  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state       <= S_IDLE;
                r_programming <= 1'b0;
                r_busy        <= 1'b0;
            end else if (w_fault) begin
                r_state       <= S_ERROR;
                r_programming <= 1'b0;
                r_busy        <= 1'b0;
                r_error       <= 1'b1;
            end else if (w_release) begin
                r_state       <= S_RELEASE;
                r_programming <= 1'b0;
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
                if (w_accept) begin
                    r_byte_count <= w_count_next;
                end
            end else begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (start) begin
                            r_state       <= S_ARM;
                            r_error       <= 1'b0;
                            r_byte_count  <= '0;
                            r_idx         <= '0;
                            r_timer       <= '0;
                            r_programming <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        r_state     <= S_STREAM;
                        r_prog_data <= r_image[r_idx];
                    end
                    S_STREAM: begin
                        if (w_accept) begin
                            r_byte_count <= w_count_next;
                            r_timer      <= '0;
                            if (w_last) begin
                                r_state <= S_WAIT_DONE;
                            end else begin
                                r_idx       <= w_idx_next;
                                r_prog_data <= r_image[w_idx_next];
                            end
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_WAIT_DONE: begin
                        r_timer <= r_timer + TW'(1);
                    end
                    S_RELEASE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign programming = r_programming;
    assign prog_data   = r_prog_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign byte_count  = r_byte_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a queue of expected image bytes is filled at
// each start and drained as the CPU side accepts bytes.
module tb_program_loader;

    localparam int RAM_BYTES = 16;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       img_we;
    logic [3:0] img_addr;
    logic [7:0] img_wdata;
    logic       start;
    logic       abort;
    logic       cpu_ready;
    logic       cpu_done_load;
    logic       programming;
    logic [7:0] prog_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] byte_count;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int done_mark = 0;

    logic [7:0] img_model [RAM_BYTES];
    logic [7:0] exp_q [$];

    program_loader #(
        .RAM_BYTES (RAM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .img_we        (img_we),
        .img_addr      (img_addr),
        .img_wdata     (img_wdata),
        .start         (start),
        .abort         (abort),
        .cpu_ready     (cpu_ready),
        .cpu_done_load (cpu_done_load),
        .programming   (programming),
        .prog_data     (prog_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_queue();
        exp_q.delete();
        for (int i = 0; i < RAM_BYTES; i++) exp_q.push_back(img_model[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_prog"}, 32'(programming), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // Pulse start, check the ARM cycle, and leave the DUT in its first STREAM cycle.
    task automatic start_load(input string tag);
        start = 1'b1;
        load_queue();
        step();
        start = 1'b0;
        check({tag, "_arm_prog"}, 32'(programming), 32'(1));
        check({tag, "_arm_busy"}, 32'(busy), 32'(1));
        check({tag, "_arm_err"}, 32'(error), 32'(0));
        check({tag, "_arm_cnt"}, 32'(byte_count), 32'(0));
        step();
    endtask

    task automatic accept_bytes(input string tag, input int n, input int gap);
        logic [7:0] want;
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap; g++) begin
                want = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
                check({tag, "_hold"}, 32'(prog_data), 32'(want));
                step();
            end
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            cpu_ready = 1'b1;
            check({tag, "_byte"}, 32'(prog_data), 32'(want));
            step();
            cpu_ready = 1'b0;
        end
    endtask

    task automatic finish_load(input string tag, input int delay);
        int seen;
        seen = done_seen;
        check({tag, "_wait_busy"}, 32'(busy), 32'(1));
        check({tag, "_wait_cnt"}, 32'(byte_count), 32'(RAM_BYTES));
        repeat (delay) step();
        cpu_done_load = 1'b1;
        step();
        cpu_done_load = 1'b0;
        check({tag, "_rel_done"}, 32'(done), 32'(1));
        check({tag, "_rel_prog"}, 32'(programming), 32'(0));
        check({tag, "_rel_busy"}, 32'(busy), 32'(0));
        check({tag, "_rel_cnt"}, 32'(byte_count), 32'(RAM_BYTES));
        step();
        check({tag, "_idle_done"}, 32'(done), 32'(0));
        check({tag, "_done_pulses"}, 32'(done_seen - seen), 32'(1));
    endtask

    initial begin
        rst = 1'b1; img_we = 1'b0; img_addr = '0; img_wdata = '0;
        start = 1'b0; abort = 1'b0; cpu_ready = 1'b0; cpu_done_load = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_err", 32'(error), 32'(0));
        check("reset_cnt", 32'(byte_count), 32'(0));
        check("reset_data", 32'(prog_data), 32'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < RAM_BYTES; i++) begin
            img_we    = 1'b1;
            img_addr  = 4'(i);
            img_wdata = 8'(8'hA0 + i);
            img_model[i] = 8'(8'hA0 + i);
            step();
        end
        img_we = 1'b0;

        // Back-to-back stream with cpu_ready held high; ready stays high in WAIT_DONE.
        cpu_ready = 1'b1;
        start_load("t1");
        accept_bytes("t1", RAM_BYTES, 0);
        cpu_ready = 1'b1;
        check("t1_last_held", 32'(prog_data), 32'(8'hAF));
        finish_load("t1", 1);
        cpu_ready = 1'b0;

        start_load("t2");
        accept_bytes("t2", RAM_BYTES, 2);
        finish_load("t2", 0);

        // No cpu_ready at all: timeout after TIMEOUT stream cycles.
        start_load("t3");
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            step();
            check("t3_no_err_yet", 32'(error), 32'(0));
            check("t3_still_prog", 32'(programming), 32'(1));
        end
        step();
        check("t3_err", 32'(error), 32'(1));
        check("t3_err_prog", 32'(programming), 32'(0));
        check("t3_err_busy", 32'(busy), 32'(0));
        check("t3_err_cnt", 32'(byte_count), 32'(0));
        step();
        check("t3_err_sticky", 32'(error), 32'(1));
        start_load("t3r");
        accept_bytes("t3r", RAM_BYTES, 0);
        finish_load("t3r", 0);

        // Premature done_load after five accepts.
        start_load("t4");
        accept_bytes("t4", 5, 0);
        done_mark = done_seen;
        cpu_done_load = 1'b1;
        step();
        cpu_done_load = 1'b0;
        check("t4_err", 32'(error), 32'(1));
        check("t4_cnt", 32'(byte_count), 32'(5));
        check("t4_prog", 32'(programming), 32'(0));
        check("t4_busy", 32'(busy), 32'(0));
        step();
        check("t4_no_done", 32'(done_seen - done_mark), 32'(0));

        // Abort after seven accepts, then a clean restart from image[0].
        start_load("t5");
        accept_bytes("t5", 7, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle_outputs("t5_abort");
        check("t5_abort_err", 32'(error), 32'(0));
        check("t5_abort_cnt", 32'(byte_count), 32'(7));
        step();
        check("t5_idle_busy", 32'(busy), 32'(0));
        start_load("t5r");
        accept_bytes("t5r", RAM_BYTES, 0);
        finish_load("t5r", 0);

        // Host write during STREAM must be ignored; byte 3 still streams as A3.
        start_load("t6");
        accept_bytes("t6", 2, 0);
        img_we = 1'b1; img_addr = 4'd3; img_wdata = 8'h55;
        step();
        img_we = 1'b0;
        accept_bytes("t6", RAM_BYTES - 2, 0);
        finish_load("t6", 0);

        // Write together with start in IDLE: new byte 3 is streamed.
        img_we = 1'b1; img_addr = 4'd3; img_wdata = 8'h3C;
        img_model[3] = 8'h3C;
        start = 1'b1;
        load_queue();
        step();
        img_we = 1'b0;
        start  = 1'b0;
        check("t7_arm_prog", 32'(programming), 32'(1));
        step();
        accept_bytes("t7", RAM_BYTES, 0);
        finish_load("t7", 0);

        // Reset mid-stream clears outputs but keeps the image.
        start_load("t8");
        accept_bytes("t8", 6, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("t8_rst");
        check("t8_rst_err", 32'(error), 32'(0));
        check("t8_rst_cnt", 32'(byte_count), 32'(0));
        check("t8_rst_data", 32'(prog_data), 32'(0));
        step();
        start_load("t8r");
        accept_bytes("t8r", RAM_BYTES, 0);
        finish_load("t8r", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
